// File: rtl/operand_requester.sv
// Per-lane operand requester: expands one accepted operand request into VRF word reads
// for the ALUA, ALUB and StoreOp queues, each throttled by a credit counter.
package operand_requester_pkg;
  localparam int unsigned NrLane         = 2;
  localparam int unsigned VLEN           = 1024;
  localparam int unsigned NrOpQueue      = 3;  // 0: ALUA (vs1), 1: ALUB (vs2), 2: StoreOp (vs3)
  localparam int unsigned ByteBlock      = 8 * NrLane;
  localparam int unsigned ByteBlockWidth = $clog2(ByteBlock);
  localparam int unsigned VLWidth        = $clog2(VLEN) + 1;
  localparam int unsigned CntWidth       = VLWidth + 3 - ByteBlockWidth;
  localparam int unsigned WordsPerVReg   = VLEN / 8 / ByteBlock;

  typedef logic [CntWidth-1:0] vrf_addr_t;
  typedef logic [VLWidth-1:0]  vlen_t;

  typedef struct packed {
    logic [NrOpQueue-1:0][4:0] vs;
    logic [NrOpQueue-1:0][1:0] vew;
    logic [NrOpQueue-1:0]      queue_req;
    vlen_t                     vl;
    vlen_t                     vstart;
  } op_req_t;

  function automatic vrf_addr_t get_vrf_addr(input logic [4:0] vs);
    return vrf_addr_t'(vs) << $clog2(WordsPerVReg);
  endfunction
endpackage

// Handshakes: a transfer happens on a rising clk_i edge where valid and ready are both
// high; valid never depends on ready and, once high, holds with stable payload until taken.
module operand_requester
  import operand_requester_pkg::*;
#(
  parameter int unsigned QueueDepth = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        op_req_valid_i,
  input  op_req_t                     op_req_i,
  output logic                        op_req_ready_o,
  output logic      [NrOpQueue-1:0]   vrf_req_valid_o,
  output vrf_addr_t [NrOpQueue-1:0]   vrf_req_addr_o,
  input  logic      [NrOpQueue-1:0]   vrf_req_ready_i,
  input  logic      [NrOpQueue-1:0]   operand_pop_i,
  output logic                        busy_o
);
  localparam int unsigned CreditWidth = $clog2(QueueDepth + 1);
  localparam logic [CreditWidth-1:0] CreditMax = CreditWidth'(QueueDepth);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  typedef logic [CntWidth-1:0]  cnt_t;
  typedef logic [VLWidth+2:0]   byte_t;

  logic [0:0]             r_state;
  cnt_t                   r_remaining [NrOpQueue];
  vrf_addr_t              r_addr      [NrOpQueue];
  logic [CreditWidth-1:0] r_credit    [NrOpQueue];
  cnt_t                   w_rem_load  [NrOpQueue];
  vrf_addr_t              w_addr_load [NrOpQueue];
  logic [NrOpQueue-1:0]   w_grant;
  logic                   w_load_any;
  logic                   w_all_done;

  for (genvar q = 0; q < NrOpQueue; q++) begin : g_queue
    byte_t w_end_byte;
    byte_t w_start_byte;
    cnt_t  w_end_word;
    cnt_t  w_start_word;

    assign w_end_byte   = byte_t'(op_req_i.vl) << op_req_i.vew[q];
    assign w_start_byte = byte_t'(op_req_i.vstart) << op_req_i.vew[q];
    // Last word rounds up so a partial block is still fetched.
    assign w_end_word   = cnt_t'((w_end_byte + byte_t'(ByteBlock - 1)) >> ByteBlockWidth);
    assign w_start_word = cnt_t'(w_start_byte >> ByteBlockWidth);

    assign w_rem_load[q]  = (op_req_i.queue_req[q] && (op_req_i.vstart < op_req_i.vl))
                            ? (w_end_word - w_start_word) : '0;
    assign w_addr_load[q] = get_vrf_addr(op_req_i.vs[q]) + w_start_word;

    assign vrf_req_valid_o[q] = (r_state == ACTIVE) && (r_remaining[q] != '0)
                                && (r_credit[q] != '0);
    assign vrf_req_addr_o[q]  = r_addr[q];
    assign w_grant[q]         = vrf_req_valid_o[q] & vrf_req_ready_i[q];

    // Credits live across requests; a grant and a pop together cancel out.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_credit[q] <= CreditMax;
      end else if (w_grant[q] && !operand_pop_i[q]) begin
        r_credit[q] <= r_credit[q] - 1'b1;
      end else if (!w_grant[q] && operand_pop_i[q] && (r_credit[q] != CreditMax)) begin
        r_credit[q] <= r_credit[q] + 1'b1;
      end
    end

    a_pop_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(operand_pop_i[q] && (r_credit[q] == CreditMax)));
  end

  always_comb begin
    w_load_any = 1'b0;
    w_all_done = 1'b1;
    for (int q = 0; q < NrOpQueue; q++) begin
      if (w_rem_load[q] != '0) w_load_any = 1'b1;
      if ((r_remaining[q] - cnt_t'(w_grant[q])) != '0) w_all_done = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      for (int q = 0; q < NrOpQueue; q++) begin
        r_remaining[q] <= '0;
        r_addr[q]      <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (op_req_valid_i) begin
            for (int q = 0; q < NrOpQueue; q++) begin
              r_remaining[q] <= w_rem_load[q];
              r_addr[q]      <= w_addr_load[q];
            end
            r_state <= w_load_any ? ACTIVE : IDLE;
          end
        end
        ACTIVE: begin
          for (int q = 0; q < NrOpQueue; q++) begin
            if (w_grant[q]) begin
              r_remaining[q] <= r_remaining[q] - 1'b1;
              r_addr[q]      <= r_addr[q] + 1'b1;
            end
          end
          if (w_all_done) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign op_req_ready_o = (r_state == IDLE);
  assign busy_o         = (r_state == ACTIVE);
endmodule

// File: tb/tb_operand_requester.sv
// Bench for operand_requester: a queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed address lists and latencies.
module tb_operand_requester;
  import operand_requester_pkg::*;

  localparam int QD = 4;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      op_req_valid = 1'b0;
  op_req_t                   op_req = '0;
  logic                      op_req_ready;
  logic      [NrOpQueue-1:0] vrf_valid;
  vrf_addr_t [NrOpQueue-1:0] vrf_addr;
  logic      [NrOpQueue-1:0] arb_ready = '1;
  logic      [NrOpQueue-1:0] operand_pop = '0;
  logic                      busy;

  logic [NrOpQueue-1:0] auto_pop = '1;
  logic [NrOpQueue-1:0] manual_pop = '0;

  // Reference model: pending addresses per queue, credits, busy flag.
  logic [CntWidth-1:0] exp_q [NrOpQueue][$];
  logic [CntWidth-1:0] got_q [NrOpQueue][$];
  int   m_credit [NrOpQueue] = '{QD, QD, QD};
  logic m_busy = 1'b0;

  int cmp_checks = 0, cmp_pass = 0, hand_checks = 0, hand_pass = 0;

  always #5 clk = ~clk;

  operand_requester #(.QueueDepth(QD)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .op_req_valid_i  (op_req_valid),
    .op_req_i        (op_req),
    .op_req_ready_o  (op_req_ready),
    .vrf_req_valid_o (vrf_valid),
    .vrf_req_addr_o  (vrf_addr),
    .vrf_req_ready_i (arb_ready),
    .operand_pop_i   (operand_pop),
    .busy_o          (busy)
  );

  function automatic void chk_c(string name, int q, logic [31:0] act, logic [31:0] exp);
    cmp_checks++;
    if (act === exp) cmp_pass++;
    else $display("FAIL %s[%0d] @%0t: got %0d, expected %0d", name, q, $time, act, exp);
  endfunction

  function automatic void chk_h(string name, logic [31:0] act, logic [31:0] exp);
    hand_checks++;
    if (act === exp) hand_pass++;
    else $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
  endfunction

  function automatic op_req_t mk(int vs1, int vs2, int vs3, int ew, logic [2:0] qr,
                                 int vl, int vstart);
    op_req_t r;
    r           = '0;
    r.vs[0]     = 5'(vs1);
    r.vs[1]     = 5'(vs2);
    r.vs[2]     = 5'(vs3);
    for (int q = 0; q < NrOpQueue; q++) r.vew[q] = 2'(ew);
    r.queue_req = qr;
    r.vl        = vlen_t'(vl);
    r.vstart    = vlen_t'(vstart);
    return r;
  endfunction

  // Model: byte span -> word span -> list of word addresses (8 words per vreg, 16 B/word).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int q = 0; q < NrOpQueue; q++) begin
        exp_q[q].delete();
        m_credit[q] = QD;
      end
      m_busy = 1'b0;
    end else begin
      logic was_busy;
      was_busy = m_busy;
      for (int q = 0; q < NrOpQueue; q++) begin
        logic g;
        g = was_busy && (exp_q[q].size() > 0) && (m_credit[q] > 0) && arb_ready[q];
        if (g) void'(exp_q[q].pop_front());
        m_credit[q] = m_credit[q] + (operand_pop[q] ? 1 : 0) - (g ? 1 : 0);
      end
      if (!was_busy && op_req_valid) begin
        for (int q = 0; q < NrOpQueue; q++) begin
          if (op_req.queue_req[q] && (op_req.vstart < op_req.vl)) begin
            int eb, sb, ew, sw;
            eb = int'(op_req.vl) << op_req.vew[q];
            sb = int'(op_req.vstart) << op_req.vew[q];
            ew = (eb + 15) / 16;
            sw = sb / 16;
            for (int w = sw; w < ew; w++) exp_q[q].push_back(CntWidth'(8 * int'(op_req.vs[q]) + w));
          end
        end
      end
      m_busy = 1'b0;
      for (int q = 0; q < NrOpQueue; q++) if (exp_q[q].size() > 0) m_busy = 1'b1;
    end
  end

  // Per-cycle compare and grant log.
  always @(negedge clk) begin
    for (int q = 0; q < NrOpQueue; q++) begin
      logic ev;
      ev = m_busy && (exp_q[q].size() > 0) && (m_credit[q] > 0);
      chk_c("vrf_valid", q, 32'(vrf_valid[q]), 32'(ev));
      if (ev) chk_c("vrf_addr", q, 32'(vrf_addr[q]), 32'(exp_q[q][0]));
      if (rst_n && vrf_valid[q] && arb_ready[q]) got_q[q].push_back(vrf_addr[q]);
    end
    chk_c("op_req_ready", 0, 32'(op_req_ready), 32'(!m_busy));
    chk_c("busy", 0, 32'(busy), 32'(m_busy));
  end

  // Consumer: pops only entries it actually holds.
  always @(negedge clk) begin
    for (int q = 0; q < NrOpQueue; q++)
      operand_pop[q] = rst_n && (auto_pop[q] || manual_pop[q]) && (m_credit[q] < QD);
  end

  task automatic send_req(input op_req_t r);
    int n;
    n = 0;
    while (m_busy && n < 3000) begin @(posedge clk); #1; n++; end
    chk_h("send_wait_bound", 32'(n < 3000), 1);
    op_req = r;
    op_req_valid = 1'b1;
    @(posedge clk); #1;
    op_req_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (busy && n < 3000) begin @(posedge clk); #1; n++; end
    chk_h("done_wait_bound", 32'(n < 3000), 1);
  endtask

  task automatic check_list(string name, int q, int base, int first, int cnt);
    chk_h({name, "_count"}, 32'(got_q[q].size() - base), 32'(cnt));
    for (int i = 0; i < cnt; i++)
      if (base + i < got_q[q].size()) chk_h(name, 32'(got_q[q][base + i]), 32'(first + i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, b0, b1, b2;
    repeat (3) @(posedge clk);
    #1;
    chk_h("rst_ready", 32'(op_req_ready), 1);
    chk_h("rst_valid", 32'(vrf_valid), 0);
    chk_h("rst_addr", 32'(vrf_addr), 0);
    chk_h("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // VADD vs1=3 vs2=5 EW32 vl=16: 4 words each, valid in cycle 1, idle in cycle 5.
    b0 = got_q[0].size(); b1 = got_q[1].size();
    send_req(mk(3, 5, 0, 2, 3'b011, 16, 0));
    chk_h("t1_first_valid", 32'(vrf_valid), 32'b011);
    chk_h("t1_first_addr_a", 32'(vrf_addr[0]), 24);
    chk_h("t1_first_addr_b", 32'(vrf_addr[1]), 40);
    wait_done(n);
    chk_h("t1_idle_latency", 32'(n), 4);
    chk_h("t1_ready_back", 32'(op_req_ready), 1);
    check_list("t1_alua", 0, b0, 24, 4);
    check_list("t1_alub", 1, b1, 40, 4);

    // vstart=5: start word 1, three reads.
    b0 = got_q[0].size();
    send_req(mk(3, 0, 0, 2, 3'b001, 16, 5));
    wait_done(n);
    check_list("t2_alua", 0, b0, 25, 3);

    // vl=0 does nothing; VSE vs3=2 EW8 vl=20 spans two words.
    b0 = got_q[0].size(); b2 = got_q[2].size();
    send_req(mk(1, 1, 1, 2, 3'b011, 0, 0));
    chk_h("t3_zero_ready", 32'(op_req_ready), 1);
    chk_h("t3_zero_valid", 32'(vrf_valid), 0);
    send_req(mk(0, 0, 2, 0, 3'b100, 20, 0));
    wait_done(n);
    check_list("t3_store", 2, b2, 16, 2);
    chk_h("t3_no_alua", 32'(got_q[0].size() - b0), 0);

    // Credit stall: 4 reads then starve, one pop releases exactly one read.
    repeat (2) @(posedge clk);
    #1;
    auto_pop = '0;
    b0 = got_q[0].size();
    send_req(mk(8, 0, 0, 3, 3'b001, 64, 0));
    repeat (8) @(posedge clk);
    #1;
    check_list("t4_stall", 0, b0, 64, 4);
    chk_h("t4_starved_valid", 32'(vrf_valid[0]), 0);
    manual_pop = 3'b001;
    @(posedge clk); #1;
    manual_pop = '0;
    chk_h("t4_pop_valid", 32'(vrf_valid[0]), 1);
    chk_h("t4_pop_addr", 32'(vrf_addr[0]), 68);
    @(posedge clk); #1;
    chk_h("t4_one_more", 32'(got_q[0].size() - b0), 5);
    chk_h("t4_starved_again", 32'(vrf_valid[0]), 0);
    auto_pop = '1;
    wait_done(n);
    check_list("t4_all", 0, b0, 64, 32);

    // Backpressure on ALUB for 3 cycles mid-stream.
    repeat (2) @(posedge clk);
    #1;
    b0 = got_q[0].size(); b1 = got_q[1].size();
    send_req(mk(1, 2, 0, 3, 3'b011, 16, 0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    arb_ready = 3'b101;
    for (int i = 0; i < 3; i++) begin
      chk_h("t5_alub_hold_valid", 32'(vrf_valid[1]), 1);
      chk_h("t5_alub_hold_addr", 32'(vrf_addr[1]), 18);
      chk_h("t5_alua_runs", 32'(vrf_valid[0]), 1);
      @(posedge clk); #1;
    end
    arb_ready = '1;
    wait_done(n);
    check_list("t5_alua", 0, b0, 8, 8);
    check_list("t5_alub", 1, b1, 16, 8);

    // Reset after 2 of 4 reads, then a fresh request sees full credits.
    repeat (2) @(posedge clk);
    #1;
    auto_pop = '0;
    send_req(mk(3, 0, 0, 2, 3'b001, 16, 0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_h("t6_rst_ready", 32'(op_req_ready), 1);
    chk_h("t6_rst_valid", 32'(vrf_valid), 0);
    chk_h("t6_rst_busy", 32'(busy), 0);
    chk_h("t6_rst_addr", 32'(vrf_addr), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    b0 = got_q[0].size();
    send_req(mk(4, 0, 0, 3, 3'b001, 64, 0));
    repeat (8) @(posedge clk);
    #1;
    check_list("t6_full_credit", 0, b0, 32, 4);
    auto_pop = '1;
    wait_done(n);
    chk_h("t6_total", 32'(got_q[0].size() - b0), 32);
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", cmp_pass + hand_pass, cmp_checks + hand_checks);
    $finish;
  end
endmodule

// File: doc/operand_requester.md
# operand_requester

Per-lane sequencer that turns one accepted `op_req_t` into a stream of VRF word-read requests for each operand queue (ALUA, ALUB, StoreOp). It sits between the issue stage's operand-request channel and the lane's VRF bank arbiter. Each queue is gated by a credit counter so reads are issued only when the downstream operand queue has space. One request is active at a time; the next is accepted after all reads for the current one have been granted.

## Interface
- `QueueDepth`, 4: entries per operand queue; initial and maximum credit count per queue.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `op_req_valid_i`  in  1  operand request valid.
- `op_req_i`  in  `op_req_t`  vs/vew/queue_req/vl/vstart of the instruction.
- `op_req_ready_o`  out  1  block can accept a request (high only in IDLE).
- `vrf_req_valid_o`  out  `NrOpQueue`  per-queue read request valid.
- `vrf_req_addr_o`  out  `NrOpQueue` x `vrf_addr_t`  per-queue VRF slice word address.
- `vrf_req_ready_i`  in  `NrOpQueue`  per-queue grant from bank arbiter.
- `operand_pop_i`  in  `NrOpQueue`  consumer popped one entry; returns one credit.
- `busy_o`  out  1  high in ACTIVE.

## Operation
- Queue-to-source mapping: ALUA←`vs[VS1]`/`vew[VS1]`, ALUB←`vs[VS2]`/`vew[VS2]`, StoreOp←`vs[VS3]`/`vew[VS3]`.
- Per queue q with `queue_req[q]`=1, at acceptance:
  - `end_byte = vl << vew`, `start_byte = vstart << vew`; both computed at `VLWidth+3` bits.
  - `end_word = ceil(end_byte / ByteBlock)`, `start_word = floor(start_byte / ByteBlock)`.
  - `remaining[q] = (vstart < vl) ? end_word - start_word : 0`.
  - `addr[q] = GetVRFAddr(vs) + start_word`.
  - Counters are `VLWidth+3-ByteBlockWidth` bits.
- Queues with `queue_req[q]`=0 get `remaining[q]=0`.
- FSM:
  - IDLE: `op_req_ready_o`=1. On `op_req_valid_i`, latch the request and load `remaining`/`addr`. Go to ACTIVE if any `remaining`≠0, otherwise stay in IDLE. This covers vl=0, vstart≥vl, VLE and an empty `queue_req`.
  - ACTIVE: `vrf_req_valid_o[q] = remaining[q]≠0 && credit[q]≠0`. On valid&ready: `addr[q]++`, `remaining[q]--`, `credit[q]--`. When every `remaining` reaches 0 after a grant, the next state is IDLE.
- Queues progress independently; one queue stalling does not block the others.
- Credits:
  - Reset to `QueueDepth`.
  - Persist across requests and are updated in both states.
  - `operand_pop_i[q]` adds 1.
  - Grant and pop in the same cycle leave the credit unchanged.
  - A pop while `credit==QueueDepth` is a protocol error, covered by an assertion. The counter saturates.
- `vrf_req_addr_o[q]` holds the latched `addr[q]` and is meaningful only while valid.

## Timing
- Reset values:
  - state IDLE, `op_req_ready_o`=1, `vrf_req_valid_o`=0, `vrf_req_addr_o`=0, `busy_o`=0.
  - all `remaining`=0, all credits=`QueueDepth`.
- Reset asserted mid-operation aborts the request immediately; all state returns to reset values, including credits.
- Handshake latency:
  - A request accepted at cycle 0 asserts its first valid in cycle 1.
  - A zero-work request returns `op_req_ready_o`=1 in cycle 1.
- Throughput:
  - With ready and credits held high, one read per queue per cycle.
  - The last grant occurs at cycle N; IDLE and ready follow at cycle N+1.
- Valid/address paths:
  - `vrf_req_valid_o` and the address depend only on registers; there is no combinational path from `vrf_req_ready_i`.
  - Once asserted, valid stays high with a stable address until granted, except when reset intervenes.
- A pop at cycle t enables a credit-starved valid at cycle t+1.

## Test plan
(NrLane=2, VLEN=1024, so ByteBlock=16 and `GetVRFAddr(v)=8v`.)
- VADD, vs1=3, vs2=5, EW32, vl=16, vstart=0, queue_req=011, arbiter always ready, pops every cycle -> ALUA addrs 24,25,26,27 and ALUB addrs 40..43 in cycles 1-4; IDLE and ready in cycle 5.
- vstart=5, vl=16, EW32, ALUA only, vs1=3 -> 3 reads at addrs 25,26,27.
- vl=0 request, then VSE vs3=2, EW8, vl=20 -> no valids for the first; second issues StoreOp addrs 16,17.
- Credit stall: EW64, vl=64, vs1=8, ALUA only, no pops -> exactly 4 reads (64..67), valid then low. A single pop -> one more read at 68 in the next cycle.
- Backpressure: hold `vrf_req_ready_i[ALUB]`=0 for 3 cycles mid-stream -> ALUB addr stable and valid high; ALUA continues; total grant counts are unchanged.
- Reset: deassert `rst_ni` after 2 of 4 reads -> all outputs return to reset values next edge. A new request afterward starts from full credits.
